// File: rtl/line_buffer.sv
// Line buffer for a KERNEL_HEIGHT-tall sliding window: stores the previous rows and emits
// one vertical pixel column per accepted pixel once enough rows have been seen.
module line_buffer #(
    parameter int DATA_WIDTH    = 8,
    parameter int IMAGE_WIDTH   = 640,
    parameter int IMAGE_HEIGHT  = 480,
    parameter int KERNEL_HEIGHT = 3,
    parameter int OUTPUT_WIDTH  = DATA_WIDTH * KERNEL_HEIGHT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OUTPUT_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int CW    = $clog2(IMAGE_WIDTH);
    localparam int RW    = $clog2(IMAGE_HEIGHT);
    localparam int LINES = KERNEL_HEIGHT - 1;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_FILL_LAST = RW'(KERNEL_HEIGHT - 2);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMAGE_HEIGHT - 1);

    typedef enum logic {
        S_FILL,
        S_STREAM
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   col_cnt;
    logic [RW-1:0]   row_cnt;
    logic            accept;
    logic            col_wrap;
    logic            fill_done;
    logic            frame_end;

    logic [DATA_WIDTH-1:0] line_mem [LINES][IMAGE_WIDTH];

    // Derived from state directly (not from in_ready) to keep the handshake free of comb loops.
    assign accept    = in_valid && ((state == S_FILL) || out_ready);
    assign col_wrap  = (col_cnt == COL_LAST);
    assign fill_done = col_wrap && (row_cnt == ROW_FILL_LAST);
    assign frame_end = col_wrap && (row_cnt == ROW_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b1;
        out_valid  = 1'b0;
        case (state)
            S_FILL: begin
                if (accept && fill_done) begin
                    state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                in_ready  = out_ready;
                out_valid = in_valid;
                if (accept && frame_end) begin
                    state_next = S_FILL;
                end
            end
            default: state_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (col_wrap) begin
                col_cnt <= '0;
                row_cnt <= frame_end ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Line memories are data only: no reset, the fill pass rewrites them before any output.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < LINES - 1; k++) begin
                line_mem[k][col_cnt] <= line_mem[k+1][col_cnt];
            end
            line_mem[LINES-1][col_cnt] <= in_data;
        end
    end

    for (genvar k = 0; k < LINES; k++) begin : g_tap
        assign out_data[DATA_WIDTH*k +: DATA_WIDTH] = line_mem[k][col_cnt];
    end
    assign out_data[DATA_WIDTH*LINES +: DATA_WIDTH] = in_data;

endmodule

// File: tb/tb_line_buffer.sv
// Directed bench for line_buffer on a 4x4 image with a 3-row kernel, pixel = row*16+col
// (plus a per-frame base offset so consecutive frames are distinguishable).
module tb_line_buffer;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int KH = 3;
    localparam int OW = DW * KH;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    line_buffer #(
        .DATA_WIDTH   (DW),
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH),
        .KERNEL_HEIGHT(KH),
        .OUTPUT_WIDTH (OW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    typedef struct {
        logic          in_valid;
        logic [DW-1:0] in_data;
        logic          out_ready;
        logic          exp_in_ready;
        logic          exp_out_valid;
        logic          chk_data;
        logic [OW-1:0] exp_out_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] col_of(input logic [DW-1:0] p);
        return {p, p - 8'h10, p - 8'h20};
    endfunction

    task automatic add(input logic v, input logic [DW-1:0] d, input logic ordy,
                       input logic e_rdy, input logic e_ov, input logic chk,
                       input logic [OW-1:0] e_data);
        vec_t x;
        x.in_valid      = v;
        x.in_data       = d;
        x.out_ready     = ordy;
        x.exp_in_ready  = e_rdy;
        x.exp_out_valid = e_ov;
        x.chk_data      = chk;
        x.exp_out_data  = e_data;
        vecs.push_back(x);
    endtask

    // One accepted-pixel cycle with out_ready=1; checks handshake and optional column.
    task automatic send(input logic [DW-1:0] p, input logic e_ov, input logic chk,
                        input logic [OW-1:0] e_data, input string tag);
        in_valid  = 1'b1;
        in_data   = p;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, " in_ready"}, in_ready, 1'b1);
        check({tag, " out_valid"}, out_valid, e_ov);
        if (chk) check({tag, " out_data"}, out_data, e_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0]  p;
        logic [OW-1:0]  got[$];
        int             gaps;
        int             budget;
        logic           accepted;

        // Frame 1 (base 0): fill with out_ready=0, bubbles, then stream with a 3-cycle stall on 0x31.
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                p = 8'(r * 16 + c);
                if (r < 2) begin
                    if (r == 1 && c == 0) add(1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, '0);
                    add(1'b1, p, 1'b0, 1'b1, 1'b0, 1'b0, '0);
                end else begin
                    if (p == 8'h22) add(1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, '0);
                    if (p == 8'h31) begin
                        for (int s = 0; s < 3; s++) add(1'b1, p, 1'b0, 1'b0, 1'b1, 1'b1, 24'h312111);
                    end
                    add(1'b1, p, 1'b1, 1'b1, 1'b1, 1'b1, col_of(p));
                end
            end
        end
        // Frame 2 (base 0x80): rows 0-1 must be silent again, rows 2-3 carry new-frame data.
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                p = 8'(8'h80 + r * 16 + c);
                if (r < 2) add(1'b1, p, 1'b1, 1'b1, 1'b0, 1'b0, '0);
                else       add(1'b1, p, 1'b1, 1'b1, 1'b1, 1'b1, col_of(p));
            end
        end

        // Reset state, with the inputs trying to push data in.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b0;
        #2;
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", in_ready, 1'b1);
        check("post-reset out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            in_valid  = vecs[i].in_valid;
            in_data   = vecs[i].in_data;
            out_ready = vecs[i].out_ready;
            @(negedge clk);
            check($sformatf("vec%0d in_ready", i), in_ready, vecs[i].exp_in_ready);
            check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].exp_out_valid);
            if (vecs[i].chk_data)
                check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_out_data);
            @(posedge clk);
            #1;
        end

        // Frame 3 (base 0x40) with random bubbles and random backpressure.
        for (int idx = 0; idx < IW * IH; idx++) begin
            p    = 8'(8'h40 + (idx / IW) * 16 + (idx % IW));
            gaps = $urandom_range(0, 2);
            repeat (gaps) begin
                in_valid  = 1'b0;
                in_data   = 8'hC3;
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("gap bubble out_valid", out_valid, 1'b0);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = p;
            accepted = 1'b0;
            budget   = 0;
            while (!accepted && budget < 40) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (in_ready) begin
                    accepted = 1'b1;
                    if (out_valid) got.push_back(out_data);
                end
                @(posedge clk);
                #1;
                budget++;
            end
            if (!accepted) check("gap accept timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        check("gap column count", got.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got.size())
                check($sformatf("gap col%0d", i), got[i], col_of(8'(8'h60 + (i / IW) * 16 + (i % IW))));
        end

        // Frame 4 (base 0): reset asserted mid-stream right after 0x22 is accepted.
        for (int i = 0; i < 8; i++) send(8'(i / IW * 16 + i % IW), 1'b0, 1'b0, '0, "f4 fill");
        send(8'h20, 1'b1, 1'b1, 24'h201000, "f4 0x20");
        send(8'h21, 1'b1, 1'b1, 24'h211101, "f4 0x21");
        send(8'h22, 1'b1, 1'b1, 24'h221202, "f4 0x22");
        in_valid  = 1'b1;
        in_data   = 8'h23;
        out_ready = 1'b1;
        #1;
        check("pre-reset out_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("mid reset out_valid", out_valid, 1'b0);
        check("mid reset in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(i / IW * 16 + i % IW), 1'b0, 1'b0, '0, "after reset fill");
        send(8'h20, 1'b1, 1'b1, 24'h201000, "after reset 0x20");
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
